spi_shift_engine: RTL and testbench
===================================

# spi_shift_engine

Parametrised serial/parallel shift engine for the SPI peripheral; the next generation of the 8-bit shift register. Runs entirely in the `clk` domain, shifting on single-cycle edge enables from the input conditioners. Adds:
- word framing on chip-select
- MSB/LSB-first mode
- bit counting
- a receive holding register with valid/ack handshake and overrun detection

## Interface
- `WIDTH`, 8: word length in bits (≥2)
- `CNT_W`, `$clog2(WIDTH)`: bit-counter width
- `clk` in 1: system clock; all state updates on posedge
- `reset` in 1: asynchronous, active-high reset
- `sampleEdge` in 1: one-cycle enable, SCLK sampling edge
- `driveEdge` in 1: one-cycle enable, SCLK drive edge
- `csActive` in 1: chip select asserted (already conditioned, active-high)
- `lsbFirst` in 1: bit order; 0 = MSB first
- `parallelLoad` in 1: one-cycle pulse, load transmit word
- `parallelDataIn` in WIDTH: transmit word
- `serialDataIn` in 1: MOSI bit
- `rxAck` in 1: consumer acknowledges `rxData`
- `serialDataOut` out 1: MISO bit, registered
- `rxData` out WIDTH: last completed receive word
- `rxValid` out 1: one-cycle pulse, new word in `rxData`
- `rxPending` out 1: word unacknowledged
- `overrun` out 1: sticky, word completed while `rxPending`
- `busy` out 1: state is SHIFT
- `bitCount` out CNT_W: bits received in current word

## Operation
- FSM states: IDLE, SHIFT.
  - IDLE→SHIFT when `csActive`=1. On entry: `lsbFirst` latched into `modeReg`, `bitCount`←0.
  - SHIFT→IDLE when `csActive`=0, from any bit position (abort).
  - On abort: `bitCount`←0, no `rxValid`, `mem` retained.
- Shift (SHIFT state, `sampleEdge`):
  - MSB-first: `mem`←{`mem`[WIDTH-2:0], `serialDataIn`}.
  - LSB-first: `mem`←{`serialDataIn`, `mem`[WIDTH-1:1]}.
  - `bitCount`+1.
- Word completion: the `sampleEdge` with `bitCount`=WIDTH-1.
  - `rxData`←the shifted value.
  - `rxValid` pulses.
  - `bitCount` wraps to 0; FSM stays in SHIFT (back-to-back words).
- Drive (SHIFT state, `driveEdge`): `serialDataOut`←`mem`[WIDTH-1] (MSB-first) or `mem`[0] (LSB-first).
- `parallelLoad`, any state:
  - `mem`←`parallelDataIn`.
  - `serialDataOut`←first bit of `parallelDataIn` per the current mode. The mode is `lsbFirst` in IDLE and `modeReg` in SHIFT.
  - `bitCount`←0.
- Priority: `reset` > abort > `parallelLoad` > `sampleEdge`.
  - `parallelLoad` with `sampleEdge` in the same cycle: the load wins and the sampled bit is dropped.
  - `sampleEdge` and `driveEdge` in the same cycle: both act. The drive uses the pre-shift `mem`.
- Handshake:
  - `rxPending` set on word completion, cleared on `rxAck`.
  - Completion with `rxAck` in the same cycle: `rxPending` stays 1 and `overrun` is not set.
  - Completion while `rxPending`=1 and `rxAck`=0: `rxData` is overwritten and `overrun`←1.
  - `overrun` is cleared only by `reset`.
- Edge enables are ignored in IDLE; `parallelLoad` is still honoured.

## Timing
- Reset values: `mem`=0, `rxData`=0, `rxValid`=0, `rxPending`=0, `overrun`=0, `serialDataOut`=0, `bitCount`=0, `busy`=0, state IDLE.
- All outputs are registered and change on the posedge where the causing enable is sampled.
- `rxValid` is high for exactly the one cycle after the completing `sampleEdge` posedge. `rxData` is stable from that cycle onwards.
- `csActive` rising: `busy`=1 one cycle later; the first `sampleEdge` is accepted in that same cycle.
- `reset` mid-word: all state returns to reset values immediately, with no `rxValid`.

## Structure
- Package `spi_pkg`:
  - state enum (IDLE, SHIFT)
  - mode constants MSB_FIRST=0, LSB_FIRST=1
  - default WIDTH
- One sub-module, `spi_bit_counter`: parametrised CNT_W counter with clear, increment, and a terminal flag at WIDTH-1. It is instantiated once for the receive bit count.

## Test plan
- **MSB-first receive:** WIDTH=8, `csActive`=1, `lsbFirst`=0, shift 1,0,1,0,0,1,0,1 → `rxData`=8'hA5, `rxValid` pulses once, `bitCount`=0.
- **LSB-first receive:** same bit stream with `lsbFirst`=1 → `rxData`=8'hA5 bit-reversed = 8'hA5 (palindrome). Repeat with stream 1,1,0,0,0,0,0,0 → 8'h03.
- **Transmit:** `parallelLoad` with 8'h3C, MSB-first → `serialDataOut` = 0 right after the load, then 0,1,1,1,1,0,0 on successive `driveEdge`s.
- **Abort:** `csActive` drops after 5 `sampleEdge`s → no `rxValid`, `bitCount`=0, `busy`=0 next cycle.
- **Overrun:** two back-to-back words without `rxAck` → second `rxValid` pulses, `overrun`=1, `rxData`=second word. Same again with `rxAck` coincident with the second completion → `overrun`=0.
- **Reset mid-word:** `reset` after 3 bits → all outputs at reset values asynchronously. The next full word is received correctly.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI shift engine family.
package spi_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } spi_state_t;

    localparam logic MSB_FIRST = 1'b0;
    localparam logic LSB_FIRST = 1'b1;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/spi_bit_counter.sv
// Receive bit counter: synchronous clear beats increment, terminal flag at the last bit of a word.
module spi_bit_counter
    import spi_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clear,
    input  logic             i_incr,
    output logic [CNT_W-1:0] o_count,
    output logic             o_terminal
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_incr) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_count    = r_count;
    assign o_terminal = (r_count == LAST);

endmodule

// File: rtl/spi_shift_engine.sv
// Serial/parallel SPI shift engine with chip-select framing, selectable bit order,
// and a receive holding register with valid/ack handshake and sticky overrun.
module spi_shift_engine
    import spi_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sampleEdge,
    input  logic             driveEdge,
    input  logic             csActive,
    input  logic             lsbFirst,
    input  logic             parallelLoad,
    input  logic [WIDTH-1:0] parallelDataIn,
    input  logic             serialDataIn,
    input  logic             rxAck,
    output logic             serialDataOut,
    output logic [WIDTH-1:0] rxData,
    output logic             rxValid,
    output logic             rxPending,
    output logic             overrun,
    output logic             busy,
    output logic [CNT_W-1:0] bitCount
);

    spi_state_t       r_state;
    spi_state_t       w_stateNext;
    logic             r_modeReg;
    logic [WIDTH-1:0] r_mem;
    logic [WIDTH-1:0] r_rxData;
    logic             r_rxValid;
    logic             r_rxPending;
    logic             r_overrun;
    logic             r_sdo;

    logic             w_busy;
    logic             w_entry;
    logic             w_abort;
    logic             w_active;
    logic             w_mode;
    logic             w_load;
    logic             w_shift;
    logic             w_drive;
    logic             w_complete;
    logic             w_terminal;
    logic             w_cntClear;
    logic             w_loadBit;
    logic             w_driveBit;
    logic [WIDTH-1:0] w_shifted;
    logic [CNT_W-1:0] w_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            IDLE:  if (csActive)  w_stateNext = SHIFT;
            SHIFT: if (!csActive) w_stateNext = IDLE;
        endcase
    end

    always_comb begin
        w_busy   = (r_state == SHIFT);
        w_entry  = (r_state == IDLE) && csActive;
        w_abort  = (r_state == SHIFT) && !csActive;
        w_active = (r_state == SHIFT) && csActive;
    end

    // Abort outranks a load, and a load outranks both edge enables in the same cycle.
    assign w_mode     = w_busy ? r_modeReg : lsbFirst;
    assign w_load     = parallelLoad && !w_abort;
    assign w_shift    = w_active && sampleEdge && !parallelLoad;
    assign w_drive    = w_active && driveEdge && !parallelLoad;
    assign w_complete = w_shift && w_terminal;
    assign w_cntClear = w_entry || w_abort || w_load || w_complete;

    assign w_shifted  = (r_modeReg == LSB_FIRST) ? {serialDataIn, r_mem[WIDTH-1:1]}
                                                 : {r_mem[WIDTH-2:0], serialDataIn};
    assign w_loadBit  = (w_mode == LSB_FIRST) ? parallelDataIn[0] : parallelDataIn[WIDTH-1];
    assign w_driveBit = (r_modeReg == LSB_FIRST) ? r_mem[0] : r_mem[WIDTH-1];

    spi_bit_counter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_rx_count (
        .clk        (clk),
        .reset      (reset),
        .i_clear    (w_cntClear),
        .i_incr     (w_shift),
        .o_count    (w_count),
        .o_terminal (w_terminal)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_modeReg <= MSB_FIRST;
            r_mem     <= '0;
            r_sdo     <= 1'b0;
        end else begin
            if (w_entry) begin
                r_modeReg <= lsbFirst;
            end
            if (w_load) begin
                r_mem <= parallelDataIn;
            end else if (w_shift) begin
                r_mem <= w_shifted;
            end
            // Drive reads the pre-shift word, so a coincident sample does not skip a bit.
            if (w_load) begin
                r_sdo <= w_loadBit;
            end else if (w_drive) begin
                r_sdo <= w_driveBit;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rxData    <= '0;
            r_rxValid   <= 1'b0;
            r_rxPending <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_rxValid <= w_complete;
            if (w_complete) begin
                r_rxData    <= w_shifted;
                r_rxPending <= 1'b1;
                if (r_rxPending && !rxAck) begin
                    r_overrun <= 1'b1;
                end
            end else if (rxAck) begin
                r_rxPending <= 1'b0;
            end
        end
    end

    assign serialDataOut = r_sdo;
    assign rxData        = r_rxData;
    assign rxValid       = r_rxValid;
    assign rxPending     = r_rxPending;
    assign overrun       = r_overrun;
    assign busy          = w_busy;
    assign bitCount      = w_count;

endmodule

// File: tb/tb_spi_shift_engine.sv
// Directed self-checking bench for spi_shift_engine at WIDTH=8.
module tb_spi_shift_engine;

    localparam int WIDTH = 8;
    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             sampleEdge = 1'b0;
    logic             driveEdge = 1'b0;
    logic             csActive = 1'b0;
    logic             lsbFirst = 1'b0;
    logic             parallelLoad = 1'b0;
    logic [WIDTH-1:0] parallelDataIn = '0;
    logic             serialDataIn = 1'b0;
    logic             rxAck = 1'b0;
    logic             serialDataOut;
    logic [WIDTH-1:0] rxData;
    logic             rxValid;
    logic             rxPending;
    logic             overrun;
    logic             busy;
    logic [CNT_W-1:0] bitCount;

    int n_checks = 0;
    int n_pass   = 0;

    spi_shift_engine #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .sampleEdge     (sampleEdge),
        .driveEdge      (driveEdge),
        .csActive       (csActive),
        .lsbFirst       (lsbFirst),
        .parallelLoad   (parallelLoad),
        .parallelDataIn (parallelDataIn),
        .serialDataIn   (serialDataIn),
        .rxAck          (rxAck),
        .serialDataOut  (serialDataOut),
        .rxData         (rxData),
        .rxValid        (rxValid),
        .rxPending      (rxPending),
        .overrun        (overrun),
        .busy           (busy),
        .bitCount       (bitCount)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        csActive = 1'b0; sampleEdge = 1'b0; driveEdge = 1'b0;
        parallelLoad = 1'b0; rxAck = 1'b0; serialDataIn = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
    endtask

    // s[7] is the first bit on the wire; rxAck is optionally raised with the last bit.
    task automatic shift_stream(input logic [7:0] s, input logic ack_last, output int vcnt);
        vcnt = 0;
        for (int i = 7; i >= 0; i--) begin
            serialDataIn = s[i];
            sampleEdge   = 1'b1;
            rxAck        = (i == 0) ? ack_last : 1'b0;
            tick();
            if (rxValid) vcnt++;
        end
        sampleEdge = 1'b0;
        rxAck      = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        n_checks++; if (rxData !== 8'h00) $display("FAIL reset_rxData got %h want 00", rxData); else n_pass++;
        n_checks++; if ({rxValid, rxPending, overrun, serialDataOut, busy} !== 5'b0)
            $display("FAIL reset_flags got %b want 00000", {rxValid, rxPending, overrun, serialDataOut, busy});
        else n_pass++;
        n_checks++; if (bitCount !== 3'd0) $display("FAIL reset_bitCount got %0d want 0", bitCount); else n_pass++;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_msb_rx();
        int vc;
        do_reset();
        lsbFirst = 1'b0; csActive = 1'b1;
        tick();
        n_checks++; if (busy !== 1'b1) $display("FAIL msb_busy got %b want 1", busy); else n_pass++;
        shift_stream(8'hA5, 1'b0, vc);
        n_checks++; if (rxData !== 8'hA5) $display("FAIL msb_rxData got %h want a5", rxData); else n_pass++;
        n_checks++; if (vc != 1) $display("FAIL msb_valid_count got %0d want 1", vc); else n_pass++;
        n_checks++; if (bitCount !== 3'd0) $display("FAIL msb_bitCount got %0d want 0", bitCount); else n_pass++;
        n_checks++; if (rxPending !== 1'b1) $display("FAIL msb_pending got %b want 1", rxPending); else n_pass++;
        tick();
        n_checks++; if (rxValid !== 1'b0) $display("FAIL msb_valid_drop got %b want 0", rxValid); else n_pass++;
        rxAck = 1'b1;
        tick();
        rxAck = 1'b0;
        n_checks++; if (rxPending !== 1'b0) $display("FAIL msb_ack got %b want 0", rxPending); else n_pass++;
        csActive = 1'b0;
        tick();
    endtask

    task automatic test_lsb_rx();
        int vc;
        do_reset();
        lsbFirst = 1'b1; csActive = 1'b1;
        tick();
        shift_stream(8'hA5, 1'b0, vc);
        n_checks++; if (rxData !== 8'hA5) $display("FAIL lsb_rxData_a5 got %h want a5", rxData); else n_pass++;
        shift_stream(8'b1100_0000, 1'b1, vc);
        n_checks++; if (rxData !== 8'h03) $display("FAIL lsb_rxData_03 got %h want 03", rxData); else n_pass++;
        n_checks++; if (overrun !== 1'b0) $display("FAIL lsb_overrun got %b want 0", overrun); else n_pass++;
        csActive = 1'b0;
        tick();
    endtask

    task automatic test_transmit();
        logic [6:0] exp_bits;
        exp_bits = 7'b0111100;
        do_reset();
        lsbFirst = 1'b0;
        parallelLoad = 1'b1; parallelDataIn = 8'h3C;
        tick();
        parallelLoad = 1'b0;
        n_checks++; if (serialDataOut !== 1'b0) $display("FAIL tx_first got %b want 0", serialDataOut); else n_pass++;
        csActive = 1'b1;
        tick();
        for (int i = 6; i >= 0; i--) begin
            serialDataIn = 1'b0;
            sampleEdge = 1'b1;
            tick();
            sampleEdge = 1'b0; driveEdge = 1'b1;
            tick();
            driveEdge = 1'b0;
            n_checks++;
            if (serialDataOut !== exp_bits[i])
                $display("FAIL tx_bit%0d got %b want %b", 6 - i, serialDataOut, exp_bits[i]);
            else n_pass++;
        end
        n_checks++; if (rxValid !== 1'b0) $display("FAIL tx_no_valid got %b want 0", rxValid); else n_pass++;
        csActive = 1'b0;
        tick();
        lsbFirst = 1'b1;
        parallelLoad = 1'b1; parallelDataIn = 8'h01;
        tick();
        parallelLoad = 1'b0;
        n_checks++; if (serialDataOut !== 1'b1) $display("FAIL tx_lsb_first got %b want 1", serialDataOut); else n_pass++;
    endtask

    task automatic test_same_cycle();
        int vc;
        do_reset();
        lsbFirst = 1'b0;
        parallelLoad = 1'b1; parallelDataIn = 8'h80;
        tick();
        parallelLoad = 1'b0;
        csActive = 1'b1;
        tick();
        serialDataIn = 1'b0; sampleEdge = 1'b1; driveEdge = 1'b1;
        tick();
        sampleEdge = 1'b0;
        n_checks++; if (serialDataOut !== 1'b1) $display("FAIL same_drive_preshift got %b want 1", serialDataOut); else n_pass++;
        tick();
        driveEdge = 1'b0;
        n_checks++; if (serialDataOut !== 1'b0) $display("FAIL same_drive_next got %b want 0", serialDataOut); else n_pass++;
        parallelLoad = 1'b1; parallelDataIn = 8'h5A; sampleEdge = 1'b1; serialDataIn = 1'b1;
        tick();
        parallelLoad = 1'b0; sampleEdge = 1'b0;
        n_checks++; if (bitCount !== 3'd0) $display("FAIL load_wins_count got %0d want 0", bitCount); else n_pass++;
        shift_stream(8'hC3, 1'b0, vc);
        n_checks++; if (rxData !== 8'hC3) $display("FAIL load_wins_rxData got %h want c3", rxData); else n_pass++;
        n_checks++; if (vc != 1) $display("FAIL load_wins_valid got %0d want 1", vc); else n_pass++;
        csActive = 1'b0;
        tick();
    endtask

    task automatic test_abort();
        int vc;
        do_reset();
        lsbFirst = 1'b0; csActive = 1'b1;
        tick();
        vc = 0;
        for (int i = 0; i < 5; i++) begin
            serialDataIn = 1'b1; sampleEdge = 1'b1;
            tick();
            if (rxValid) vc++;
        end
        sampleEdge = 1'b0;
        n_checks++; if (bitCount !== 3'd5) $display("FAIL abort_pre_count got %0d want 5", bitCount); else n_pass++;
        csActive = 1'b0;
        tick();
        if (rxValid) vc++;
        n_checks++; if (busy !== 1'b0) $display("FAIL abort_busy got %b want 0", busy); else n_pass++;
        n_checks++; if (bitCount !== 3'd0) $display("FAIL abort_count got %0d want 0", bitCount); else n_pass++;
        n_checks++; if (vc != 0) $display("FAIL abort_valid got %0d want 0", vc); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int vc;
        do_reset();
        lsbFirst = 1'b0; csActive = 1'b1;
        tick();
        shift_stream(8'hA5, 1'b0, vc);
        shift_stream(8'h3C, 1'b0, vc);
        n_checks++; if (vc != 1) $display("FAIL ovr_valid got %0d want 1", vc); else n_pass++;
        n_checks++; if (overrun !== 1'b1) $display("FAIL ovr_set got %b want 1", overrun); else n_pass++;
        n_checks++; if (rxData !== 8'h3C) $display("FAIL ovr_rxData got %h want 3c", rxData); else n_pass++;
        do_reset();
        csActive = 1'b1;
        tick();
        shift_stream(8'hA5, 1'b0, vc);
        shift_stream(8'h3C, 1'b1, vc);
        n_checks++; if (overrun !== 1'b0) $display("FAIL ack_ovr got %b want 0", overrun); else n_pass++;
        n_checks++; if (rxPending !== 1'b1) $display("FAIL ack_pending got %b want 1", rxPending); else n_pass++;
        n_checks++; if (rxData !== 8'h3C) $display("FAIL ack_rxData got %h want 3c", rxData); else n_pass++;
        csActive = 1'b0;
        tick();
    endtask

    task automatic test_reset_midword();
        int vc;
        do_reset();
        lsbFirst = 1'b0;
        parallelLoad = 1'b1; parallelDataIn = 8'hFF;
        tick();
        parallelLoad = 1'b0;
        csActive = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            serialDataIn = 1'b1; sampleEdge = 1'b1;
            tick();
        end
        sampleEdge = 1'b0;
        n_checks++; if (bitCount !== 3'd3) $display("FAIL mid_pre_count got %0d want 3", bitCount); else n_pass++;
        #2;
        reset = 1'b1;
        #1;
        n_checks++; if ({busy, serialDataOut, rxValid, rxPending, overrun} !== 5'b0)
            $display("FAIL mid_async_flags got %b want 00000", {busy, serialDataOut, rxValid, rxPending, overrun});
        else n_pass++;
        n_checks++; if (bitCount !== 3'd0) $display("FAIL mid_async_count got %0d want 0", bitCount); else n_pass++;
        reset = 1'b0;
        tick();
        shift_stream(8'h96, 1'b0, vc);
        n_checks++; if (rxData !== 8'h96) $display("FAIL mid_next_word got %h want 96", rxData); else n_pass++;
        n_checks++; if (vc != 1) $display("FAIL mid_next_valid got %0d want 1", vc); else n_pass++;
        csActive = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_msb_rx();
        test_lsb_rx();
        test_transmit();
        test_same_cycle();
        test_abort();
        test_back_to_back();
        test_reset_midword();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
